counter7_positioner: RTL and testbench
======================================

Name: counter7_positioner

Overview:
- Control-side driver for the mod-7 up/down counter. The counter responds to a direction bit `x` (0 = up, 1 = down).
- This block receives a target position (0..6) and computes the shortest wrap-around path to it. It then issues step/direction commands one per clock.
- It keeps a shadow copy of the counter position, including the counter's threshold output y (pos >= 3).
- It reports done when the shadow position equals the target. It sits between a host command port and the counter's x input, with `step` gating the counter's clock enable.

Parameters:
- MOD, 7, counter modulus; legal positions 0..MOD-1.
- W, 3, position width; must satisfy 2^W >= MOD.
- THRESH, 3, shadow y asserts when pos >= THRESH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command request; sampled only in IDLE.
- target  in  W  requested position; latched on an accepted start.
- busy  out  1  high in MOVE and DONE.
- step  out  1  high for exactly one cycle per position change; drives the counter enable.
- x  out  1  direction for the current step: 0 = increment, 1 = decrement. Same encoding as the counter's x.
- pos  out  W  shadow position. Updated at the clock edge that ends a step cycle.
- y  out  1  (pos >= THRESH); combinational from pos.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse when start is presented with target >= MOD.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - At reset: state = IDLE, pos = 0, step = 0, x = 0, busy = 0, done = 0, err = 0. Consequently y = 0.
- States are IDLE, MOVE and DONE.
- IDLE:
  - If start=1 and target >= MOD: err=1 next cycle, target is not latched, and the state stays IDLE.
  - If start=1 and target is legal: latch target, compute the step count and direction, then go to MOVE, or to DONE if the step count is 0.
- Path computation:
  - up = (target - pos) mod MOD.
  - If up <= MOD/2 (integer division, i.e. 3): dir = up (x=0) and rem = up.
  - Otherwise: dir = down (x=1) and rem = MOD - up.
  - MOD is odd, so no tie case exists.
  - Width rule: do the subtraction at W+1 bits and add MOD when the result is negative. No modulo operator.
- MOVE:
  - step=1 and x=dir every cycle.
  - Each edge: pos <= pos+1 with wrap MOD-1 -> 0, or pos-1 with wrap 0 -> MOD-1.
  - rem decrements each cycle. When rem reaches 0, go to DONE; the last step edge moves the state to DONE.
- DONE: done=1 for one cycle, step=0, then go to IDLE. A start in this cycle is ignored.
- Latency:
  - start accepted at cycle N: MOVE occupies cycles N+1..N+k, and done is high at cycle N+1+k.
  - k = 0 gives done at N+1.
  - k is at most 3.
- x holds its last value outside MOVE; it is don't-care when step=0.
- start while busy is ignored, with no queueing. target changes while busy have no effect.
- Reset mid-operation: reset wins over everything. The move aborts and pos returns to 0, matching the counter's own reset.
- pos never holds a value >= MOD.

Decomposition:
- Shared package `counter7_pkg`:
  - MOD, W and THRESH constants.
  - State enum {IDLE, MOVE, DONE}.
  - Direction constants DIR_UP=0, DIR_DN=1.
- Sub-module `mod_wrap_step`:
  - Combinational. Inputs pos, dir; output next position with wrap.
  - Reused for the shadow-position update and by the verification reference model.

Test Plan:
- Reset, then start with target=2 at N -> x=0 and step=1 at N+1 and N+2; pos goes 0->1->2; done at N+3; y=0 throughout; busy high N+1..N+3.
- From pos=2, target=6 -> up=4 > 3, so x=1 with 3 steps: pos 2->1->0->6 (wraps through 0); done at N+4; y goes 0->0->0->1.
- From pos=6, target=3 -> x=1 with 3 steps: 6->5->4->3; y stays 1; done at N+4. Then from pos=3, target=0 -> x=1 with 3 steps; y falls to 0 on reaching 2.
- pos=3 and target=3 -> no step asserted; done at N+1; busy high for 1 cycle. Then target=7 with start -> err pulse at N+1; pos, busy and done unchanged.
- start with target=5 from pos=0 (up=5 > 3, so down, 2 steps: 0->6->5). Pulse start again at N+1 with target=1 -> ignored; done at N+3; pos=5.
- rst asserted at N+2 during a 3-step move -> at N+3: pos=0, step=0, busy=0, and done never pulses. A start at N+3 with target=1 proceeds normally.

Source files
------------

// File: rtl/counter7_pkg.sv
// Shared constants and types for the mod-7 counter positioner.
// Positions, state encoding and step direction codes.
package counter7_pkg;

    localparam int MOD    = 7;
    localparam int W      = 3;
    localparam int THRESH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/mod_wrap_step.sv
// One-position move on a modulo-MOD ring.
// Wraps MOD-1 -> 0 going up and 0 -> MOD-1 going down.
module mod_wrap_step
    import counter7_pkg::*;
#(
    parameter int MOD = counter7_pkg::MOD,
    parameter int W   = counter7_pkg::W
) (
    input  logic [W-1:0] pos_i,
    input  logic         dir_i,
    output logic [W-1:0] nxt_o
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);
    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        nxt_o = pos_i;
        if (dir_i == DIR_DN) begin
            nxt_o = (pos_i == '0) ? TOP : (pos_i - ONE);
        end else begin
            nxt_o = (pos_i >= TOP) ? '0 : (pos_i + ONE);
        end
    end

endmodule

// File: rtl/counter7_positioner.sv
// Drives a mod-7 up/down counter to a target along the shortest ring path,
// tracking a shadow copy of the counter position and its threshold output.
module counter7_positioner
    import counter7_pkg::*;
#(
    parameter int MOD    = counter7_pkg::MOD,
    parameter int W      = counter7_pkg::W,
    parameter int THRESH = counter7_pkg::THRESH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] target,
    output logic         busy,
    output logic         step,
    output logic         x,
    output logic [W-1:0] pos,
    output logic         y,
    output logic         done,
    output logic         err
);

    localparam logic [W:0]   MODX = (W + 1)'(MOD);
    localparam logic [W-1:0] MODW = W'(MOD);
    localparam logic [W-1:0] HALF = W'(MOD / 2);
    localparam logic [W-1:0] THR  = W'(THRESH);
    localparam logic [W-1:0] ONE  = W'(1);

    state_e       state_q, state_d;
    logic [W-1:0] pos_q, pos_d;
    logic [W-1:0] rem_q, rem_d;
    logic         dir_q, dir_d;
    logic         err_q, err_d;

    logic [W:0]   diff;
    logic [W-1:0] up;
    logic [W-1:0] rem_new;
    logic         dir_new;
    logic         tgt_bad;
    logic [W-1:0] pos_step;

    mod_wrap_step #(
        .MOD (MOD),
        .W   (W)
    ) u_step (
        .pos_i (pos_q),
        .dir_i (dir_q),
        .nxt_o (pos_step)
    );

    // Shortest path: the wider subtraction exposes the borrow, then fold back.
    always_comb begin
        tgt_bad = ({1'b0, target} >= MODX);
        diff    = {1'b0, target} - {1'b0, pos_q};
        if (diff[W]) begin
            diff = diff + MODX;
        end
        up = diff[W-1:0];
        if (up <= HALF) begin
            dir_new = DIR_UP;
            rem_new = up;
        end else begin
            dir_new = DIR_DN;
            rem_new = MODW - up;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (tgt_bad) begin
                        err_d = 1'b1;
                    end else if (rem_new == '0) begin
                        state_d = DONE;
                    end else begin
                        dir_d   = dir_new;
                        rem_d   = rem_new;
                        state_d = MOVE;
                    end
                end
            end
            MOVE: begin
                pos_d = pos_step;
                rem_d = rem_q - ONE;
                if (rem_q == ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            rem_q   <= '0;
            dir_q   <= DIR_UP;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign step = (state_q == MOVE);
    assign done = (state_q == DONE);
    assign x    = dir_q;
    assign pos  = pos_q;
    assign y    = (pos_q >= THR);
    assign err  = err_q;

endmodule

// File: tb/tb_counter7_positioner.sv
// Scoreboard bench for counter7_positioner against a cycle model.
// Directed plan sequences followed by a random command stream.
module tb_counter7_positioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] target = 3'd0;
    logic       busy, step, x, y, done, err;
    logic [2:0] pos;

    typedef struct packed {
        logic       step;
        logic       x;
        logic       busy;
        logic       done;
        logic       err;
        logic       y;
        logic [2:0] pos;
    } exp_t;

    exp_t q[$];
    int   errs = 0;
    int   checks = 0;

    int m_st = 0;
    int m_p = 0;
    int m_rem = 0;
    int m_d = 0;
    int m_err = 0;

    counter7_positioner dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .target (target),
        .busy   (busy),
        .step   (step),
        .x      (x),
        .pos    (pos),
        .y      (y),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Independent model: 0=idle, 1=move, 2=done.
    task automatic model(input logic r, input logic s, input logic [2:0] t);
        int   up;
        exp_t e;
        if (r) begin
            m_st = 0; m_p = 0; m_rem = 0; m_d = 0; m_err = 0;
        end else begin
            m_err = 0;
            case (m_st)
                0: if (s) begin
                    if (int'(t) >= 7) begin
                        m_err = 1;
                    end else begin
                        up = (int'(t) - m_p + 7) % 7;
                        if (up == 0) begin
                            m_st = 2;
                        end else begin
                            m_d   = (up <= 3) ? 0 : 1;
                            m_rem = (up <= 3) ? up : 7 - up;
                            m_st  = 1;
                        end
                    end
                end
                1: begin
                    m_p = m_d ? (m_p + 6) % 7 : (m_p + 1) % 7;
                    m_rem--;
                    if (m_rem == 0) m_st = 2;
                end
                default: m_st = 0;
            endcase
        end
        e.step = (m_st == 1);
        e.x    = m_d[0];
        e.busy = (m_st != 0);
        e.done = (m_st == 2);
        e.err  = m_err[0];
        e.y    = (m_p >= 3);
        e.pos  = 3'(m_p);
        q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic s, input logic [2:0] t);
        exp_t e;
        rst = r; start = s; target = t;
        model(r, s, t);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = q.pop_front();
            chk("pos", pos, e.pos);
            chk("step", step, e.step);
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
            chk("err", err, e.err);
            chk("y", y, e.y);
            if (e.step) chk("x", x, e.x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 3'd0);
        chk("rst_pos", pos, 0);
        chk("rst_busy", busy, 0);

        cyc(1'b0, 1'b1, 3'd2);
        idle(5);
        chk("up2_pos", pos, 2);

        cyc(1'b0, 1'b1, 3'd6);
        idle(5);
        chk("wrap_pos", pos, 6);
        chk("wrap_y", y, 1);

        cyc(1'b0, 1'b1, 3'd3);
        idle(5);
        cyc(1'b0, 1'b1, 3'd0);
        idle(5);
        chk("dn0_pos", pos, 0);

        cyc(1'b0, 1'b1, 3'd3);
        idle(5);
        cyc(1'b0, 1'b1, 3'd3);
        chk("k0_done", done, 1);
        idle(2);
        cyc(1'b0, 1'b1, 3'd7);
        chk("bad_err", err, 1);
        chk("bad_pos", pos, 3);
        idle(2);

        cyc(1'b0, 1'b1, 3'd0);
        idle(5);
        cyc(1'b0, 1'b1, 3'd5);
        cyc(1'b0, 1'b1, 3'd1);
        idle(4);
        chk("ign_pos", pos, 5);

        cyc(1'b0, 1'b1, 3'd2);
        cyc(1'b0, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 3'd0);
        chk("abort_pos", pos, 0);
        chk("abort_step", step, 0);
        cyc(1'b0, 1'b1, 3'd1);
        idle(4);
        chk("after_pos", pos, 1);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 59) == 0,
                $urandom_range(0, 2) == 0,
                3'($urandom_range(0, 7)));
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
